// File: rtl/prog_sequencer_if.sv
// Control/status bundle between the instruction decoder and prog_sequencer.
// The decoder drives the master side and the sequencer implements the slave side.
interface prog_sequencer_if #(
    parameter int A  = 10,
    parameter int NF = 4
);
    localparam int FSW = (NF > 1) ? $clog2(NF) : 1;

    logic           Start;
    logic           Halt;
    logic           BranchAbsEn;
    logic           BranchRelEn;
    logic           CallEn;
    logic           RetEn;
    logic [NF-1:0]  Flags;
    logic [FSW-1:0] FlagSel;
    logic [A-1:0]   Target;
    logic [A-1:0]   ProgCtr;
    logic           Done;
    logic           Running;
    logic           RasErr;

    modport master (
        output Start, Halt, BranchAbsEn, BranchRelEn, CallEn, RetEn,
        output Flags, FlagSel, Target,
        input  ProgCtr, Done, Running, RasErr
    );

    modport slave (
        input  Start, Halt, BranchAbsEn, BranchRelEn, CallEn, RetEn,
        input  Flags, FlagSel, Target,
        output ProgCtr, Done, Running, RasErr
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program counter sequencer: Start pulses pick a program slot, then branch/call/return/halt.
// Define PROG_SEQ_RAS_EN to build the return-address stack; otherwise calls are plain jumps.
module prog_sequencer #(
    parameter int A      = 10,
    parameter int NPROG  = 4,
    parameter int STRIDE = 100,
    parameter int NF     = 4,
    parameter int RAS_D  = 4
) (
    input logic             Clk,
    input logic             Reset_n,
    prog_sequencer_if.slave seq
);
    localparam int CW = $clog2(NPROG + 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                state;
    logic [A-1:0]          pc;
    logic [CW-1:0]         start_cnt;
    logic                  start_r;
    logic                  done;
    logic                  running;
    logic                  rise;
    logic                  fall;
    logic                  launch;
    logic                  advance;
    logic                  rel_take;
    logic [A-1:0]          pc_inc;
    logic [A-1:0]          pc_rel;
    logic [A-1:0]          pc_next;
    logic signed [A-1:0]   rel_off;

    // Slot k starts at (k-1)*STRIDE, folded into the PC width.
    function automatic logic [A-1:0] base_addr(input logic [CW-1:0] k);
        logic [31:0] prod;
        prod = (32'(k) - 32'd1) * 32'(STRIDE);
        return prod[A-1:0];
    endfunction

    assign rise     = seq.Start & ~start_r;
    assign fall     = ~seq.Start & start_r;
    assign launch   = fall && (start_cnt != '0);
    assign advance  = (state == RUN) && !launch && !seq.Halt;
    assign rel_take = seq.BranchRelEn && seq.Flags[seq.FlagSel];
    assign rel_off  = signed'(seq.Target);
    assign pc_inc   = pc + A'(1);
    assign pc_rel   = pc + unsigned'(rel_off);

`ifdef PROG_SEQ_RAS_EN
    localparam int SPW = $clog2(RAS_D + 1);
    localparam int IW  = (RAS_D > 1) ? $clog2(RAS_D) : 1;

    logic [A-1:0]   ras [RAS_D];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic           do_push;
    logic           do_pop;
    logic           ras_fault;
    logic           ras_err;

    assign sp_m1 = sp - SPW'(1);

    always_comb begin
        pc_next   = pc_inc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        ras_fault = 1'b0;
        if (seq.RetEn) begin
            // Underflow falls back to a plain increment.
            if (sp != '0) begin
                pc_next = ras[sp_m1[IW-1:0]];
                do_pop  = 1'b1;
            end else begin
                ras_fault = 1'b1;
            end
        end else if (seq.CallEn) begin
            pc_next = seq.Target;
            if (sp != SPW'(RAS_D)) do_push = 1'b1;
            else                   ras_fault = 1'b1;
        end else if (seq.BranchAbsEn) begin
            pc_next = seq.Target;
        end else if (rel_take) begin
            pc_next = pc_rel;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sp      <= '0;
            ras_err <= 1'b0;
        end else if (launch) begin
            sp <= '0;
        end else if (advance) begin
            if (do_push)   sp      <= sp + SPW'(1);
            if (do_pop)    sp      <= sp_m1;
            if (ras_fault) ras_err <= 1'b1;
        end
    end

    // Stack entries are data only; sp decides which are valid.
    always_ff @(posedge Clk) begin
        if (advance && do_push) ras[sp[IW-1:0]] <= pc_inc;
    end

    assign seq.RasErr = ras_err;
`else
    logic unused_ret;

    always_comb begin
        pc_next = pc_inc;
        if (seq.CallEn || seq.BranchAbsEn) pc_next = seq.Target;
        else if (rel_take)                 pc_next = pc_rel;
    end

    assign unused_ret = seq.RetEn;
    assign seq.RasErr = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pc        <= '0;
            start_cnt <= '0;
            start_r   <= 1'b0;
            done      <= 1'b0;
            running   <= 1'b0;
        end else begin
            start_r <= seq.Start;
            if (rise && (start_cnt != CW'(NPROG))) start_cnt <= start_cnt + CW'(1);
            // A Start fall restarts from any state and outranks Halt.
            if (launch) begin
                state   <= RUN;
                pc      <= base_addr(start_cnt);
                done    <= 1'b0;
                running <= 1'b1;
            end else if (state == RUN) begin
                if (seq.Halt) begin
                    state   <= HALT;
                    done    <= 1'b1;
                    running <= 1'b0;
                end else begin
                    pc <= pc_next;
                end
            end
        end
    end

    assign seq.ProgCtr = pc;
    assign seq.Done    = done;
    assign seq.Running = running;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed table-driven bench for prog_sequencer (A=10, NPROG=4, STRIDE=100, NF=4, RAS_D=4).
// Adapts its expectations to whether PROG_SEQ_RAS_EN is defined.
module tb_prog_sequencer;
    localparam logic [5:0] S  = 6'b100000;
    localparam logic [5:0] H  = 6'b010000;
    localparam logic [5:0] BA = 6'b001000;
    localparam logic [5:0] BR = 6'b000100;
    localparam logic [5:0] CA = 6'b000010;
    localparam logic [5:0] RE = 6'b000001;
    localparam logic [2:0] D  = 3'b100;
    localparam logic [2:0] R  = 3'b010;
    localparam logic [2:0] Z  = 3'b000;
`ifdef PROG_SEQ_RAS_EN
    localparam logic [2:0] EA = 3'b001;
`else
    localparam logic [2:0] EA = 3'b000;
`endif

    typedef struct {
        logic [5:0] ctl;
        logic [3:0] flags;
        logic [1:0] fsel;
        logic [9:0] target;
        logic [9:0] pc;
        logic [2:0] st;
    } vec_t;

    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;
    vec_t vecs[$];

    prog_sequencer_if #(.A(10), .NF(4)) bus ();

    prog_sequencer #(
        .A(10), .NPROG(4), .STRIDE(100), .NF(4), .RAS_D(4)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .seq(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void add(input logic [5:0] c, input logic [3:0] f, input logic [1:0] s,
                                input logic [9:0] t, input logic [9:0] p, input logic [2:0] st);
        vec_t v;
        v.ctl = c; v.flags = f; v.fsel = s; v.target = t; v.pc = p; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic check(input string what, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step%0d: got %0d expected %0d", what, idx, got, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [9:0] p, input logic [2:0] st);
        check("ProgCtr", idx, 32'(bus.ProgCtr), 32'(p));
        check("Done",    idx, 32'(bus.Done),    32'(st[2]));
        check("Running", idx, 32'(bus.Running), 32'(st[1]));
        check("RasErr",  idx, 32'(bus.RasErr),  32'(st[0]));
    endtask

    task automatic step(input logic [5:0] c, input logic [3:0] f, input logic [1:0] s, input logic [9:0] t);
        @(negedge Clk);
        {bus.Start, bus.Halt, bus.BranchAbsEn, bus.BranchRelEn, bus.CallEn, bus.RetEn} = c;
        bus.Flags   = f;
        bus.FlagSel = s;
        bus.Target  = t;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Idle, then three Start pulses selecting slots 1..3.
        for (int i = 0; i < 5; i++) add(6'b0, 4'h0, 2'd0, 10'd0, 10'd0, Z);
        add(S,       4'h0, 2'd0, 10'd0,   10'd0,    Z);
        add(6'b0,    4'h0, 2'd0, 10'd0,   10'd0,    R);
        add(6'b0,    4'h0, 2'd0, 10'd0,   10'd1,    R);
        add(S,       4'h0, 2'd0, 10'd0,   10'd2,    R);
        add(6'b0,    4'h0, 2'd0, 10'd0,   10'd100,  R);
        add(S,       4'h0, 2'd0, 10'd0,   10'd101,  R);
        add(6'b0,    4'h0, 2'd0, 10'd0,   10'd200,  R);
        // Branches: taken/not-taken relative, priority, wrap.
        add(BA,      4'h0, 2'd0, 10'd10,  10'd10,   R);
        add(BR,      4'h4, 2'd2, 10'h3FD, 10'd7,    R);
        add(BA,      4'h0, 2'd0, 10'd10,  10'd10,   R);
        add(BR,      4'hB, 2'd2, 10'h3FD, 10'd11,   R);
        add(BA | BR, 4'hF, 2'd0, 10'd20,  10'd20,   R);
        add(BR,      4'h1, 2'd0, 10'h3FF, 10'd19,   R);
        add(BA,      4'h0, 2'd0, 10'd1023, 10'd1023, R);
        add(6'b0,    4'h0, 2'd0, 10'd0,   10'd0,    R);
`ifdef PROG_SEQ_RAS_EN
        add(BA,      4'h0, 2'd0, 10'd5,   10'd5,    R);
        add(CA,      4'h0, 2'd0, 10'd40,  10'd40,   R);
        add(RE,      4'h0, 2'd0, 10'd0,   10'd6,    R);
        add(CA | BA, 4'h0, 2'd0, 10'd30,  10'd30,   R);
        add(RE | CA, 4'h0, 2'd0, 10'd90,  10'd7,    R);
        for (int i = 0; i < 4; i++) add(CA, 4'h0, 2'd0, 10'd100, 10'd100, R);
        add(CA,      4'h0, 2'd0, 10'd100, 10'd100,  R | EA);
        for (int i = 0; i < 3; i++) add(RE, 4'h0, 2'd0, 10'd0, 10'd101, R | EA);
        add(RE,      4'h0, 2'd0, 10'd0,   10'd8,    R | EA);
        add(RE,      4'h0, 2'd0, 10'd0,   10'd9,    R | EA);
`else
        add(BA,      4'h0, 2'd0, 10'd5,   10'd5,    R);
        add(CA,      4'h0, 2'd0, 10'd40,  10'd40,   R);
        add(RE,      4'h0, 2'd0, 10'd0,   10'd41,   R);
        add(RE | CA, 4'h0, 2'd0, 10'd60,  10'd60,   R);
        add(CA | BA, 4'h0, 2'd0, 10'd30,  10'd30,   R);
`endif
        // Halt, ignored controls in HALT, restart, count saturation, fall beats Halt.
        add(BA,      4'h0, 2'd0, 10'd50,  10'd50,   R | EA);
        add(H | BA,  4'h0, 2'd0, 10'd7,   10'd50,   D | EA);
        add(BA | CA, 4'hF, 2'd0, 10'd3,   10'd50,   D | EA);
        add(S,       4'h0, 2'd0, 10'd0,   10'd50,   D | EA);
        add(6'b0,    4'h0, 2'd0, 10'd0,   10'd300,  R | EA);
        add(S,       4'h0, 2'd0, 10'd0,   10'd301,  R | EA);
        add(H,       4'h0, 2'd0, 10'd0,   10'd300,  R | EA);
        add(H,       4'h0, 2'd0, 10'd0,   10'd300,  D | EA);

        {bus.Start, bus.Halt, bus.BranchAbsEn, bus.BranchRelEn, bus.CallEn, bus.RetEn} = 6'b0;
        bus.Flags   = 4'h0;
        bus.FlagSel = 2'd0;
        bus.Target  = 10'd0;
        Reset_n     = 1'b1;
        #1 Reset_n  = 1'b0;
        @(posedge Clk);
        #1;
        check_all(-1, 10'd0, Z);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ctl, vecs[i].flags, vecs[i].fsel, vecs[i].target);
            check_all(i, vecs[i].pc, vecs[i].st);
        end

        // Asynchronous reset in the middle of a running program.
        step(S,    4'h0, 2'd0, 10'd0);
        check_all(200, 10'd300, D | EA);
        step(6'b0, 4'h0, 2'd0, 10'd0);
        check_all(201, 10'd300, R | EA);
        step(BA,   4'h0, 2'd0, 10'd123);
        check_all(202, 10'd123, R | EA);
        #1;
        Reset_n = 1'b0;
        #1;
        check_all(203, 10'd0, Z);
        @(negedge Clk);
        Reset_n = 1'b1;
        // Fresh pulse selects slot 1 again.
        step(S,    4'h0, 2'd0, 10'd0);
        check_all(204, 10'd0, Z);
        step(6'b0, 4'h0, 2'd0, 10'd0);
        check_all(205, 10'd0, R);
        // Return on an empty stack increments and flags the error.
        step(RE,   4'h0, 2'd0, 10'd0);
        check_all(206, 10'd1, R | EA);
        step(BA,   4'h0, 2'd0, 10'd9);
        check_all(207, 10'd9, R | EA);
        step(S,    4'h0, 2'd0, 10'd0);
        check_all(208, 10'd10, R | EA);
        step(6'b0, 4'h0, 2'd0, 10'd0);
        check_all(209, 10'd100, R | EA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
